// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ byte producers share a single
//   uart_Tx transmitter. One byte is granted per arbitration, held stable
//   on tx_data, and launched with tx_transmit until the transmitter reports
//   busy. The requester is acknowledged on the first busy cycle.
//
// Parameters
//   DATA_BITS      character width forwarded to uart_Tx
//   NUM_REQ        number of requesters (2..8)
//   TIMEOUT_CYCLES start-acknowledge timeout, only with UART_ARB_TIMEOUT_EN
//
// Build option
//   UART_ARB_TIMEOUT_EN  when defined, a launch that never sees busy is
//                        abandoned after TIMEOUT_CYCLES and reported on
//                        timeout_err; otherwise LAUNCH waits indefinitely
//                        and timeout_err is tied low.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   req          per-requester level request
//   req_data     flattened bytes, slice i = [i*DATA_BITS +: DATA_BITS]
//   ack          one-cycle pulse when requester i's byte is accepted
//   tx_transmit  transmit strobe to uart_Tx
//   tx_data      byte to uart_Tx
//   tx_busy      busy from uart_Tx
//   grant_id     current or most recent winner
//   active       high whenever not IDLE
//   timeout_err  one-cycle pulse on a start timeout
module uart_tx_arbiter #(
  parameter int DATA_BITS      = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          tx_transmit,
  output logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active,
  output logic                          timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  // An out-of-range configuration never grants instead of misbehaving.
  localparam bit PARAMS_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) && (TIMEOUT_CYCLES >= 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, SENDING, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;
  logic [DATA_BITS-1:0]  tx_data_q, tx_data_d;

  logic                  win_found;
  logic [GW-1:0]         win_idx;
  logic [DATA_BITS-1:0]  win_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  timeout_err_q, timeout_err_d;
`endif

  // Round-robin search starting just after the last served requester.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
    win_data = req_data[int'(win_idx)*DATA_BITS +: DATA_BITS];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A busy transmitter here belongs to someone else; do not grant.
        if (PARAMS_OK && win_found && !tx_busy) begin
          grant_id_d = win_idx;
          tx_data_d  = win_data;
          state_d    = LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      LAUNCH: begin
        if (tx_busy) begin
          state_d = SENDING;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on this byte; rotate priority so the next one gets a turn.
          timeout_err_d = 1'b1;
          last_grant_d  = grant_id_q;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      SENDING: begin
        if (!tx_busy) state_d = DRAIN;
      end
      DRAIN: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      tx_data_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign tx_transmit = (state_q == LAUNCH);
  assign active      = (state_q != IDLE);
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;

  // Ack is raised in the very cycle busy is first seen during LAUNCH.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign ack[gi] = (state_q == LAUNCH) && tx_busy && (grant_id_q == GW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_transmit;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_arbiter #(.DATA_BITS(8), .NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .tx_transmit(tx_transmit), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  ack;
    logic        tx;
    logic [7:0]  txd;
    logic [1:0]  gid;
    logic        act;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    end
  endtask

  // Runs one transfer from IDLE/grant through DRAIN, returning in the
  // following IDLE cycle at posedge+1.
  task automatic xfer(input int exp_id, input logic [7:0] exp_d, input string tag);
    int n;
    n = 0;
    while (!tx_transmit && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_launch"}, 32'(tx_transmit), 32'd1);
    check({tag, "_gid"},    32'(grant_id),    32'(exp_id));
    check({tag, "_data"},   32'(tx_data),     32'(exp_d));
    check({tag, "_noack"},  32'(ack),         32'd0);
    tx_busy = 1'b1; #1;
    check({tag, "_ack"},    32'(ack),         32'(4'b0001 << exp_id));
    @(posedge clk); #1;
    check({tag, "_send_tx"},  32'(tx_transmit), 32'd0);
    check({tag, "_send_ack"}, 32'(ack),         32'd0);
    tx_busy = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drain_act"}, 32'(active), 32'd1);
    @(posedge clk); #1;
    check({tag, "_idle_act"},  32'(active), 32'd0);
    $display("xfer %s: grant_id=%0d tx_data=%02h", tag, grant_id, tx_data);
  endtask

  initial begin
    tbl[0]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{4'b0100, 32'h00A50000, 1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 1'b1};
    tbl[2]  = '{4'b0000, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1};
    tbl[3]  = '{4'b0000, 32'h00A50000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1};
    tbl[4]  = '{4'b0000, 32'h00A50000, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1};
    tbl[5]  = '{4'b0000, 32'h00A50000, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1};
    tbl[6]  = '{4'b0000, 32'h00A50000, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
    tbl[7]  = '{4'b0001, 32'h0000005A, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
    tbl[8]  = '{4'b0001, 32'h0000005A, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
    tbl[9]  = '{4'b0001, 32'h0000005A, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0};
    tbl[10] = '{4'b0001, 32'h0000005A, 1'b0, 4'b0000, 1'b1, 8'h5A, 2'd0, 1'b1};
    tbl[11] = '{4'b0000, 32'h0000005A, 1'b1, 4'b0001, 1'b1, 8'h5A, 2'd0, 1'b1};
    tbl[12] = '{4'b0000, 32'h0000005A, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd0, 1'b1};
    tbl[13] = '{4'b0000, 32'h0000005A, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd0, 1'b1};
    tbl[14] = '{4'b0000, 32'h0000005A, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd0, 1'b0};
    tbl[15] = '{4'b0010, 32'h00003C00, 1'b0, 4'b0000, 1'b0, 8'h5A, 2'd0, 1'b0};
    tbl[16] = '{4'b0010, 32'h0000FF00, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1, 1'b1};
    tbl[17] = '{4'b0010, 32'h0000FF00, 1'b1, 4'b0010, 1'b1, 8'h3C, 2'd1, 1'b1};
    tbl[18] = '{4'b0000, 32'h0000FF00, 1'b1, 4'b0000, 1'b0, 8'h3C, 2'd1, 1'b1};
    tbl[19] = '{4'b0000, 32'h0000FF00, 1'b0, 4'b0000, 1'b0, 8'h3C, 2'd1, 1'b1};
    tbl[20] = '{4'b0000, 32'h0000FF00, 1'b0, 4'b0000, 1'b0, 8'h3C, 2'd1, 1'b1};
    tbl[21] = '{4'b0000, 32'h0000FF00, 1'b0, 4'b0000, 1'b0, 8'h3C, 2'd1, 1'b0};

    reset = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",   32'(tx_transmit), 32'd0);
    check("rst_data", 32'(tx_data),     32'd0);
    check("rst_ack",  32'(ack),         32'd0);
    check("rst_gid",  32'(grant_id),    32'd0);
    check("rst_act",  32'(active),      32'd0);
    check("rst_to",   32'(timeout_err), 32'd0);
    reset = 1'b0;

    // Single request, busy-in-idle hold-off, data change after grant.
    for (int i = 0; i < 22; i++) begin
      req = tbl[i].req; req_data = tbl[i].data; tx_busy = tbl[i].busy;
      #1;
      check($sformatf("row%0d_ack", i), 32'(ack),         32'(tbl[i].ack));
      check($sformatf("row%0d_tx", i),  32'(tx_transmit), 32'(tbl[i].tx));
      check($sformatf("row%0d_txd", i), 32'(tx_data),     32'(tbl[i].txd));
      check($sformatf("row%0d_gid", i), 32'(grant_id),    32'(tbl[i].gid));
      check($sformatf("row%0d_act", i), 32'(active),      32'(tbl[i].act));
      check($sformatf("row%0d_to", i),  32'(timeout_err), 32'd0);
      $display("row %0d: req=%b busy=%b ack=%b tx=%b txd=%02h gid=%0d act=%b",
               i, req, tx_busy, ack, tx_transmit, tx_data, grant_id, active);
      @(posedge clk); #1;
    end

    // Fresh reset, then all four requesting continuously: order 0,1,2,3,0.
    reset = 1'b1; req = '0; tx_busy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    req_data = 32'h44332211;
    req = 4'b1111;
    xfer(0, 8'h11, "rr0");
    xfer(1, 8'h22, "rr1");
    xfer(2, 8'h33, "rr2");
    xfer(3, 8'h44, "rr3");
    xfer(0, 8'h11, "rr4");

    // Reset while SENDING aborts with all outputs cleared and no ack.
    req = 4'b1000;
    @(posedge clk); #1;
    check("abort_gid", 32'(grant_id), 32'd3);
    tx_busy = 1'b1;
    @(posedge clk); #1;
    check("abort_sending", 32'(tx_transmit), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_tx",   32'(tx_transmit), 32'd0);
    check("abort_data", 32'(tx_data),     32'd0);
    check("abort_ack",  32'(ack),         32'd0);
    check("abort_gid0", 32'(grant_id),    32'd0);
    check("abort_act",  32'(active),      32'd0);
    check("abort_to",   32'(timeout_err), 32'd0);
    $display("abort: reset applied in SENDING, active=%b tx_data=%02h", active, tx_data);
    @(posedge clk); #1;
    reset = 1'b0; tx_busy = 1'b0; req = 4'b1010;
    xfer(1, 8'h22, "post_rst");

    // Launch that never sees busy.
    req = 4'b0011;
    @(posedge clk); #1;
    check("to_launch", 32'(tx_transmit), 32'd1);
    check("to_gid",    32'(grant_id),    32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (i < 64) begin
        check($sformatf("to_wait%0d", i), 32'({tx_transmit, timeout_err}), 32'b10);
      end else begin
        check("to_pulse", 32'({tx_transmit, timeout_err}), 32'b01);
        check("to_noack", 32'(ack), 32'd0);
      end
    end
    @(posedge clk); #1;
    check("to_next_tx",  32'(tx_transmit), 32'd1);
    check("to_next_gid", 32'(grant_id),    32'd1);
    check("to_next_to",  32'(timeout_err), 32'd0);
    tx_busy = 1'b1; #1;
    check("to_next_ack", 32'(ack), 32'b0010);
    $display("timeout: pulse observed, next grant_id=%0d", grant_id);
`else
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d", i), 32'({tx_transmit, timeout_err, ack}), 32'b100000);
    end
    tx_busy = 1'b1; #1;
    check("hold_ack", 32'(ack), 32'b0001);
    $display("no-timeout: LAUNCH held 70 cycles, grant_id=%0d", grant_id);
`endif
    @(posedge clk); #1;
    tx_busy = 1'b0; req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("end_idle", 32'(active), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
